// File: rtl/uart16550_pkg.sv
// Shared constants for the UART16550 stream sequencer: register map,
// LSR/LCR bit positions, TX FIFO depth and the sequencer state encoding.
package uart16550_pkg;

    // Register addresses on the 3-bit uart_regs bus
    localparam logic [2:0] ADDR_RBR = 3'd0;
    localparam logic [2:0] ADDR_THR = 3'd0;
    localparam logic [2:0] ADDR_DLL = 3'd0;
    localparam logic [2:0] ADDR_IER = 3'd1;
    localparam logic [2:0] ADDR_DLM = 3'd1;
    localparam logic [2:0] ADDR_FCR = 3'd2;
    localparam logic [2:0] ADDR_LCR = 3'd3;
    localparam logic [2:0] ADDR_LSR = 3'd5;

    // LSR bit indices
    localparam int LSR_DR     = 0;
    localparam int LSR_ERR_LO = 1;
    localparam int LSR_ERR_HI = 4;
    localparam int LSR_THRE   = 5;

    // LCR divisor-latch access bit
    localparam int         LCR_DLAB      = 7;
    localparam logic [7:0] LCR_DLAB_MASK = 8'h80;

    // Number of free slots in an empty TX FIFO
    localparam logic [4:0] TX_FIFO_DEPTH = 5'd16;

    // Sequencer states: six init writes, then the poll/transfer loop
    typedef enum logic [3:0] {
        S_DLAB = 4'd0,
        S_DLL  = 4'd1,
        S_DLM  = 4'd2,
        S_LCR  = 4'd3,
        S_FCR  = 4'd4,
        S_IER  = 4'd5,
        S_POLL = 4'd6,
        S_TX   = 4'd7,
        S_RX   = 4'd8
    } state_t;

endpackage

// File: rtl/uart16550_ctrl.sv
// Sequencer and byte-stream adapter for the uart_regs register core.
// Programs divisor, line, FIFO and interrupt registers after reset, then
// polls LSR every cycle and moves bytes between the streams and THR/RBR.
//
// Handshakes: a TX byte is transferred in the cycle where tx_valid and
// tx_ready are both high (tx_ready is a one-cycle pulse in S_TX); an RX
// byte is transferred in the cycle where rx_valid and rx_ready are both
// high. tx_data must be stable while tx_valid is high.
module uart16550_ctrl
    import uart16550_pkg::*;
#(
    parameter logic [15:0] DIVISOR = 16'd27,
    parameter logic [7:0]  LCR_VAL = 8'h03,
    parameter logic [7:0]  FCR_VAL = 8'hC7,
    parameter logic [7:0]  IER_VAL = 8'h00
) (
    input  logic       HCLK,
    input  logic       HRESETn,
    input  logic       tx_valid,
    input  logic [7:0] tx_data,
    output logic       tx_ready,
    output logic       rx_valid,
    output logic [7:0] rx_data,
    input  logic       rx_ready,
    output logic       init_done,
    output logic       line_err,
    output logic [2:0] uart_addr,
    output logic [7:0] uart_wdata,
    input  logic [7:0] uart_rdata,
    output logic       uart_we,
    output logic       uart_re,
    output state_t     dbg_state
);

    state_t     state;
    state_t     state_nxt;
    logic [4:0] credit;
    logic       thre_q;

    logic       bus_we;
    logic       bus_re;
    logic [2:0] bus_addr;
    logic [7:0] bus_wdata;
    logic       bus_tx_ready;

    assign dbg_state = state;

    // Bus strobes are held off while reset is asserted so nothing reaches
    // uart_regs and no pending TX byte is acknowledged during reset.
    assign uart_we    = HRESETn & bus_we;
    assign uart_re    = HRESETn & bus_re;
    assign uart_addr  = HRESETn ? bus_addr  : 3'd0;
    assign uart_wdata = HRESETn ? bus_wdata : 8'h00;
    assign tx_ready   = HRESETn & bus_tx_ready;

    // State register
    always_ff @(posedge HCLK) begin
        if (!HRESETn) state <= S_DLAB;
        else          state <= state_nxt;
    end

    // Next-state and bus decode; each state issues exactly one access
    always_comb begin
        state_nxt    = state;
        bus_we       = 1'b0;
        bus_re       = 1'b0;
        bus_addr     = 3'd0;
        bus_wdata    = 8'h00;
        bus_tx_ready = 1'b0;
        case (state)
            S_DLAB: begin
                bus_we    = 1'b1;
                bus_addr  = ADDR_LCR;
                bus_wdata = LCR_VAL | LCR_DLAB_MASK;
                state_nxt = S_DLL;
            end
            S_DLL: begin
                bus_we    = 1'b1;
                bus_addr  = ADDR_DLL;
                bus_wdata = DIVISOR[7:0];
                state_nxt = S_DLM;
            end
            S_DLM: begin
                bus_we    = 1'b1;
                bus_addr  = ADDR_DLM;
                bus_wdata = DIVISOR[15:8];
                state_nxt = S_LCR;
            end
            S_LCR: begin
                bus_we    = 1'b1;
                bus_addr  = ADDR_LCR;
                bus_wdata = LCR_VAL & ~LCR_DLAB_MASK;
                state_nxt = S_FCR;
            end
            S_FCR: begin
                bus_we    = 1'b1;
                bus_addr  = ADDR_FCR;
                bus_wdata = FCR_VAL;
                state_nxt = S_IER;
            end
            S_IER: begin
                bus_we    = 1'b1;
                bus_addr  = ADDR_IER;
                bus_wdata = IER_VAL;
                state_nxt = S_POLL;
            end
            S_POLL: begin
                // LSR is read and acted on in the same cycle; RX wins over TX.
                // rx_valid is the registered flag, so a same-cycle consume
                // does not free the holding register for this decision.
                bus_re   = 1'b1;
                bus_addr = ADDR_LSR;
                if (uart_rdata[LSR_DR] && !rx_valid)
                    state_nxt = S_RX;
                else if (tx_valid && (uart_rdata[LSR_THRE] || credit != 5'd0))
                    state_nxt = S_TX;
            end
            S_TX: begin
                bus_we       = 1'b1;
                bus_addr     = ADDR_THR;
                bus_wdata    = tx_data;
                bus_tx_ready = 1'b1;
                state_nxt    = S_POLL;
            end
            S_RX: begin
                bus_re    = 1'b1;
                bus_addr  = ADDR_RBR;
                state_nxt = S_POLL;
            end
            default: state_nxt = S_DLAB;
        endcase
    end

    // TX credit: an observed THRE means the FIFO is empty, so refill to depth
    always_ff @(posedge HCLK) begin
        if (!HRESETn) begin
            credit <= 5'd0;
            thre_q <= 1'b0;
        end else begin
            if (state == S_POLL && state_nxt == S_TX)
                thre_q <= uart_rdata[LSR_THRE];
            if (state == S_TX)
                credit <= (thre_q ? TX_FIFO_DEPTH : credit) - 5'd1;
        end
    end

    // RX holding register: loaded by the RBR read, emptied by the consumer
    always_ff @(posedge HCLK) begin
        if (!HRESETn) begin
            rx_valid <= 1'b0;
            rx_data  <= 8'h00;
        end else if (state == S_RX) begin
            rx_valid <= 1'b1;
            rx_data  <= uart_rdata;
        end else if (rx_valid && rx_ready) begin
            rx_valid <= 1'b0;
        end
    end

    // init_done latches once the last configuration write has been issued
    always_ff @(posedge HCLK) begin
        if (!HRESETn)           init_done <= 1'b0;
        else if (state == S_IER) init_done <= 1'b1;
    end

    // line_err pulses for one cycle after a poll that sees any error bit
    always_ff @(posedge HCLK) begin
        if (!HRESETn) line_err <= 1'b0;
        else          line_err <= (state == S_POLL) &&
                                  (uart_rdata[LSR_ERR_HI:LSR_ERR_LO] != 4'd0);
    end

endmodule
